// File: rtl/pc_redirect_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_ctrl_pkg
//  Brief    : Shared target-select codes, FSM states and default PCs for the
//             fetch-PC redirect controller.
//  Revision : 1.0  initial release
// ============================================================================
package pc_redirect_ctrl_pkg;

    localparam logic [1:0] TSEL_PCREL = 2'b00;
    localparam logic [1:0] TSEL_JABS  = 2'b01;
    localparam logic [1:0] TSEL_REG   = 2'b10;
    localparam logic [1:0] TSEL_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        PCS_RUN    = 2'd0,
        PCS_PEND   = 2'd1,
        PCS_BUBBLE = 2'd2
    } pcs_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0040_0004;

    // Word offset of a conditional branch, sign-extended to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_target_gen.sv
`default_nettype none
// ============================================================================
//  Module   : pc_target_gen
//  Brief    : Combinational redirect target selection and register-target
//             misalignment detection.
//  Revision : 1.0  initial release
// ============================================================================
module pc_target_gen
    import pc_redirect_ctrl_pkg::*;
(
    input  logic [1:0]  target_sel,
    input  logic        branch_decision,
    input  logic [31:0] id_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_value,
    output logic [31:0] target,
    output logic        misalign
);

    logic [31:0] w_id_pc_plus4;

    assign w_id_pc_plus4 = id_pc + 32'd4;

    always_comb begin
        target = w_id_pc_plus4 + branch_offset(imm16);
        case (target_sel)
            TSEL_PCREL, TSEL_RSVD: target = w_id_pc_plus4 + branch_offset(imm16);
            TSEL_JABS:             target = {w_id_pc_plus4[31:28], instr_index, 2'b00};
            TSEL_REG:              target = rs_value;
            default:               target = w_id_pc_plus4 + branch_offset(imm16);
        endcase
    end

    assign misalign = branch_decision && (target_sel == TSEL_REG) && (rs_value[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_redirect_ctrl
//  Brief    : Fetch-PC register and redirect controller (RUN/PEND/BUBBLE).
//             Define PC_DELAY_SLOT_EN for MIPS branch-delay-slot behaviour.
//  Revision : 1.0  initial release
// ============================================================================
module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
    parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        stall_in,
    input  logic        branch_decision,
    input  logic        exception_flag,
    input  logic [1:0]  target_sel,
    input  logic [31:0] id_pc,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_value,
    output logic [31:0] if_pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] link_addr,
    output logic        if_valid,
    output logic        flush_out,
    output logic        addr_err_out
);

`ifdef PC_DELAY_SLOT_EN
    localparam logic        c_delay_slot = 1'b1;
    localparam logic [31:0] c_link_ofs   = 32'd8;
`else
    localparam logic        c_delay_slot = 1'b0;
    localparam logic [31:0] c_link_ofs   = 32'd4;
`endif

    pcs_e        state_q, state_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] pending_pc_q, pending_pc_d;

    logic [31:0] w_target;
    logic        w_misalign;
    logic        w_misalign_take;
    logic        w_flush;

    pc_target_gen u_target_gen (
        .target_sel      (target_sel),
        .branch_decision (branch_decision),
        .id_pc           (id_pc),
        .imm16           (imm16),
        .instr_index     (instr_index),
        .rs_value        (rs_value),
        .target          (w_target),
        .misalign        (w_misalign)
    );

    // While pending, the branch in ID is the one already latched (and it was aligned).
    assign w_misalign_take = w_misalign && (state_q != PCS_PEND);

    always_comb begin
        state_d      = state_q;
        if_pc_d      = if_pc_q;
        pending_pc_d = pending_pc_q;
        w_flush      = 1'b0;

        if (exception_flag || w_misalign_take) begin
            if_pc_d      = EXC_VECTOR;
            pending_pc_d = '0;
            state_d      = PCS_BUBBLE;
            w_flush      = 1'b1;
        end else if (state_q == PCS_PEND) begin
            if (!stall_in) begin
                if_pc_d      = pending_pc_q;
                pending_pc_d = '0;
                state_d      = c_delay_slot ? PCS_RUN : PCS_BUBBLE;
                w_flush      = !c_delay_slot;
            end
        end else if (branch_decision) begin
            if (stall_in) begin
                pending_pc_d = w_target;
                state_d      = PCS_PEND;
            end else begin
                if_pc_d = w_target;
                state_d = c_delay_slot ? PCS_RUN : PCS_BUBBLE;
                w_flush = !c_delay_slot;
            end
        end else begin
            // A bubble holds the PC so the redirect target is refetched as valid.
            if (!stall_in && (state_q == PCS_RUN)) begin
                if_pc_d = if_pc_q + 32'd4;
            end
            state_d = PCS_RUN;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q      <= PCS_RUN;
            if_pc_q      <= RESET_PC;
            pending_pc_q <= '0;
        end else begin
            state_q      <= state_d;
            if_pc_q      <= if_pc_d;
            pending_pc_q <= pending_pc_d;
        end
    end

    assign if_pc        = if_pc_q;
    assign pc_plus4     = if_pc_q + 32'd4;
    assign link_addr    = id_pc + c_link_ofs;
    assign if_valid     = (state_q != PCS_BUBBLE);
    assign flush_out    = w_flush && !reset_in;
    assign addr_err_out = w_misalign_take && !reset_in;

endmodule
`default_nettype wire
